opcode_issuer: RTL and testbench
================================

# opcode_issuer

Front-end counterpart of the instruction decoder: accepts one-hot control requests (the same 8-bit control-signal encoding the decoder produces), encodes each into its 4-bit opcode, and buffers the result in a small FIFO. Buffered opcodes are then presented to the decoder side over a valid/ready handshake. The block sits between the control/test sequencer and the decoder, and provides rate decoupling plus detection of malformed requests.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2
- CTRL_W, 8: control-vector width
- OP_W, 4: opcode width; CTRL_W ≤ 2**OP_W
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ctrl  in  CTRL_W  one-hot control request
- req_ready  out  1  block can accept; = (count < DEPTH)
- op_valid  out  1  opcode available; = (count != 0)
- opcode  out  OP_W  head-of-FIFO opcode; 0 when op_valid=0
- op_ready  in  1  consumer takes opcode
- invalid  out  1  one-cycle pulse: the request accepted last cycle was rejected
- err_count  out  8  saturating count of rejected requests
- count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Accept: req_valid && req_ready at a rising edge. Pop: op_valid && op_ready at a rising edge.
- Encoding: set bit k of req_ctrl maps to opcode k. Examples: 8'b00000001 -> 4'b0000, 8'b00000010 -> 4'b0001, 8'b00000100 -> 4'b0010, 8'b10000000 -> 4'b0111.
- Encodable request: pushed to the FIFO tail.
- Rejected request: consumed (handshake completes), not pushed. invalid=1 for the following cycle, err_count += 1, saturating at 255.
- req_ctrl == 0 is always rejected.
- Multi-hot handling depends on configuration; see Configuration.
- FIFO: read/write pointers wrap modulo DEPTH. count is updated by +1 on push, −1 on pop, and is unchanged when push and pop happen in the same cycle.
- Full (count == DEPTH): req_ready=0, even if a pop occurs in the same cycle.
- Empty: op_valid=0, opcode=0. op_ready is ignored.
- No bypass: a request never reaches opcode in the same cycle it is accepted.
- Ordering: strict FIFO; the opcode sequence matches the order of accepted, encodable requests.

## Timing
- Reset values: count=0, pointers=0, op_valid=0, opcode=0, invalid=0, err_count=0, req_ready=1.
- While reset=1, all handshakes are ignored and no push or pop occurs.
- Reset mid-operation discards all buffered entries in the cycle it is sampled.
- Latency: a request accepted at edge N into an empty FIFO gives op_valid=1 and the correct opcode after edge N.
- Throughput: one accept plus one pop per cycle sustained.
- invalid asserts after edge N for a rejected accept at edge N and deasserts after edge N+1, unless another rejection occurs.
- Outputs op_valid, opcode, req_ready and count derive only from registered state. There is no combinational path from inputs to outputs.

## Configuration
- OPCODE_ISSUER_STRICT_EN defined: any req_ctrl without exactly one set bit is rejected.
- OPCODE_ISSUER_STRICT_EN undefined: multi-hot requests are priority-encoded, lowest set bit wins (e.g. 8'b00000110 -> 4'b0001). Only the all-zero request is rejected.

## Structure
- Shared package isa_pkg:
  - OPCODE_W, CTRL_W
  - opcode constants OP_INSTR1=4'b0000, OP_INSTR2=4'b0001, OP_INSTR3=4'b0010
  - opcode_t typedef
  - The decoder uses the same package.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) holds storage, pointers and count.
- The encoder/validity check and error counter live in opcode_issuer.

## Test plan
- Reset, then single request 8'b00000100 with op_ready=1 -> op_valid high one cycle later with opcode 4'b0010, popped, count returns to 0.
- op_ready=0, push 8'b1, 8'b10, 8'b100, 8'b1000 -> count=4, req_ready=0. Then raise op_ready -> opcodes 0,1,2,3 pop in order, req_ready=1 after first pop.
- req_ctrl=0 accepted -> invalid pulses for exactly one cycle, err_count=1, count unchanged.
- req_ctrl=8'b00000110: with macro -> rejected, err_count+1; without macro -> opcode 4'b0001 enqueued.
- Simultaneous push and pop at count=2 -> count stays 2, order preserved; 300 rejected requests -> err_count=255.
- Reset asserted with count=3 -> next cycle op_valid=0, count=0, opcode=0; a fresh push afterwards is delivered normally.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the opcode issuer and the instruction decoder.
// Both blocks agree on the control-vector width, the opcode width and the
// named opcode values through this package.
package isa_pkg;

    localparam int OPCODE_W = 4;
    localparam int CTRL_W   = 8;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_INSTR1 = 4'b0000;
    localparam opcode_t OP_INSTR2 = 4'b0001;
    localparam opcode_t OP_INSTR3 = 4'b0010;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO holding encoded opcodes between the request side and the
// decoder side. Pointers wrap modulo DEPTH (a power of two) and a separate
// occupancy counter distinguishes full from empty. The read data is taken
// straight from storage, so the head entry is visible with no extra latency
// and never bypasses from the write port.
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;

    logic w_doPush;
    logic w_doPop;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == FULL_CNT);
    assign o_count  = r_count;
    assign o_rdata  = r_mem[r_rdPtr];

    // A push into a full FIFO or a pop from an empty one is silently dropped
    // so the pointers and the counter can never drift apart.
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    // Storage writes; no reset needed since occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (!reset && w_doPush) begin
            r_mem[r_wrPtr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
    // the count where it was while both pointers advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/opcode_issuer.sv
// Opcode issuer: encodes one-hot control requests into opcodes, buffers them
// in a FIFO and presents them to the decoder over a valid/ready handshake.
// Malformed requests are consumed but dropped; each one pulses 'invalid' for
// a cycle and bumps a saturating error counter.
//
// Build option OPCODE_ISSUER_STRICT_EN: when defined, any request without
// exactly one set bit is rejected. When undefined, multi-hot requests are
// priority-encoded with the lowest set bit winning and only the all-zero
// request is rejected.
module opcode_issuer #(
    parameter int DEPTH  = 4,
    parameter int CTRL_W = isa_pkg::CTRL_W,
    parameter int OP_W   = isa_pkg::OPCODE_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [CTRL_W-1:0]        req_ctrl,
    output logic                     req_ready,
    output logic                     op_valid,
    output logic [OP_W-1:0]          opcode,
    input  logic                     op_ready,
    output logic                     invalid,
    output logic [7:0]               err_count,
    output logic [$clog2(DEPTH):0]   count
);

    import isa_pkg::*;

    logic              w_accept;
    logic              w_found;
    logic              w_encodable;
    logic [OP_W-1:0]   w_code;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic [OP_W-1:0]   w_headOp;
    logic              r_invalid;
    logic [7:0]        r_errCount;

    // Scan from the top bit down so the lowest set bit is the last to write
    // w_code; that gives lowest-bit priority for multi-hot requests.
    always_comb begin
        w_code  = '0;
        w_found = 1'b0;
        for (int k = CTRL_W - 1; k >= 0; k--) begin
            if (req_ctrl[k]) begin
                w_code  = OP_W'(k);
                w_found = 1'b1;
            end
        end
    end

`ifdef OPCODE_ISSUER_STRICT_EN
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_encodable = w_found && ((req_ctrl & (req_ctrl - CTRL_W'(1))) == '0);
`else
    assign w_encodable = w_found;
`endif

    // Handshakes are ignored while reset is held so nothing moves in the FIFO.
    assign w_accept  = req_valid && req_ready && !reset;
    assign w_push    = w_accept && w_encodable;
    assign w_pop     = op_valid && op_ready && !reset;

    sync_fifo #(
        .WIDTH (OP_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_code),
        .i_pop   (w_pop),
        .o_rdata (w_headOp),
        .o_count (count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Everything visible to the decoder comes from FIFO state, never from
    // the request inputs, so there is no combinational through-path.
    assign req_ready = !w_full;
    assign op_valid  = !w_empty;
    assign opcode    = w_empty ? '0 : w_headOp;
    assign invalid   = r_invalid;
    assign err_count = r_errCount;

    // A rejected request raises invalid for exactly the following cycle and
    // counts toward err_count, which sticks at its maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_invalid  <= 1'b0;
            r_errCount <= '0;
        end else begin
            r_invalid <= w_accept && !w_encodable;
            if (w_accept && !w_encodable && (r_errCount != 8'hFF)) begin
                r_errCount <= r_errCount + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_opcode_issuer.sv
// Self-checking bench for opcode_issuer. A driver issues requests and keeps
// a queue of expected opcodes; a monitor on the falling edge compares every
// output against that queue and the expected error state, and retires queue
// entries as the decoder side takes them.
module tb_opcode_issuer;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic [7:0] req_ctrl;
    logic       req_ready;
    logic       op_valid;
    logic [3:0] opcode;
    logic       op_ready;
    logic       invalid;
    logic [7:0] err_count;
    logic [2:0] count;

    int         nVectors;
    int         nMiscompares;

    logic [3:0] expQ[$];
    logic       expInvalid;
    int         expErr;

    logic       pendRst;
    logic       pendAccept;
    logic       pendEnc;
    logic [3:0] pendOp;

    opcode_issuer #(
        .DEPTH  (DEPTH),
        .CTRL_W (8),
        .OP_W   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ctrl  (req_ctrl),
        .req_ready (req_ready),
        .op_valid  (op_valid),
        .opcode    (opcode),
        .op_ready  (op_ready),
        .invalid   (invalid),
        .err_count (err_count),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoding: opcode is the index of the lowest set bit; the
    // acceptance rule depends on the strictness build option.
    function automatic void modelEncode(input logic [7:0] c, output logic enc, output logic [3:0] op);
        op = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            if (c[k]) op = 4'(k);
        end
`ifdef OPCODE_ISSUER_STRICT_EN
        enc = ($countones(c) == 1);
`else
        enc = (c != 8'd0);
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Just after each rising edge: retire the effect of the request sampled
    // at that edge into the model, then drive the inputs for the next edge.
    task automatic applyStimulus(input logic v, input logic [7:0] c, input logic r, input logic rst);
        @(posedge clk);
        #1;
        if (pendRst) begin
            expQ.delete();
            expInvalid = 1'b0;
            expErr     = 0;
        end else begin
            expInvalid = pendAccept && !pendEnc;
            if (pendAccept && !pendEnc && expErr < 255) expErr++;
            if (pendAccept && pendEnc) expQ.push_back(pendOp);
        end
        reset     = rst;
        req_valid = v;
        req_ctrl  = c;
        op_ready  = r;
        pendRst    = rst;
        pendAccept = !rst && v && (expQ.size() < DEPTH);
        modelEncode(c, pendEnc, pendOp);
    endtask

    // Monitor: compare all outputs mid-cycle, then pop the scoreboard when
    // the decoder side takes the head opcode at the coming edge.
    always @(negedge clk) begin
        logic [3:0] expOp;
        expOp = (expQ.size() != 0) ? expQ[0] : 4'd0;
        checkOutput("count",     32'(count),     32'(expQ.size()));
        checkOutput("req_ready", 32'(req_ready), 32'(expQ.size() < DEPTH));
        checkOutput("op_valid",  32'(op_valid),  32'(expQ.size() != 0));
        checkOutput("opcode",    32'(opcode),    32'(expOp));
        checkOutput("invalid",   32'(invalid),   32'(expInvalid));
        checkOutput("err_count", 32'(err_count), 32'(expErr));
        if (!reset && op_ready && expQ.size() != 0) begin
            void'(expQ.pop_front());
        end
    end

    initial begin
        logic [7:0] c;
        nVectors     = 0;
        nMiscompares = 0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_ctrl     = 8'd0;
        op_ready     = 1'b0;
        expInvalid   = 1'b0;
        expErr       = 0;
        pendRst      = 1'b1;
        pendAccept   = 1'b0;
        pendEnc      = 1'b0;
        pendOp       = 4'd0;

        // Reset, then release
        repeat (2) applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);

        // Single request with the consumer ready
        applyStimulus(1'b1, 8'b0000_0100, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

        // Fill to DEPTH with the consumer stalled, try one more, then drain
        applyStimulus(1'b1, 8'b0000_0001, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'b0000_0010, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'b0000_0100, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'b0000_1000, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'b0001_0000, 1'b0, 1'b0);
        repeat (6) applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

        // All-zero request is consumed and rejected
        applyStimulus(1'b1, 8'd0, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);

        // Multi-hot request
        applyStimulus(1'b1, 8'b0000_0110, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

        // Simultaneous push and pop at occupancy 2
        applyStimulus(1'b1, 8'b0000_0001, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'b0000_0010, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'b0000_0100, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'b0000_1000, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'b0100_0000, 1'b1, 1'b0);
        repeat (5) applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

        // Error counter saturation
        repeat (300) applyStimulus(1'b1, 8'd0, 1'b1, 1'b0);
        repeat (2) applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

        // Reset mid-operation with three entries buffered
        applyStimulus(1'b1, 8'b0000_0001, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'b0000_0010, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'b1000_0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'd0, 1'b0, 0);
        applyStimulus(1'b1, 8'b0010_0000, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

        // Randomized traffic: one-hot, zero and arbitrary vectors
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 3))
                0:       c = 8'h01 << $urandom_range(0, 7);
                1:       c = 8'h00;
                default: c = 8'($urandom);
            endcase
            applyStimulus(($urandom_range(0, 3) != 0), c, ($urandom_range(0, 2) != 0), 1'b0);
        end

        // Drain whatever is left
        repeat (DEPTH + 4) applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("drain_count", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
